// File: rtl/instr_reader.sv
// Batch instruction reader: walks a block of instruction-register entries,
// executes each opcode on its signed operands and hands results out one at a time.
module instr_reader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          start_addr,
   input  logic [ADDR_W:0]            num_instr,
   output logic [ADDR_W-1:0]          read_pointer,
   input  logic [3:0]                 rd_opcode,
   input  logic signed [DATA_W-1:0]   rd_operand_a,
   input  logic signed [DATA_W-1:0]   rd_operand_b,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic signed [2*DATA_W-1:0] result,
   output logic [ADDR_W-1:0]          res_addr,
   output logic                       res_err,
   output logic                       busy,
   output logic                       done,
   output logic [1:0]                 state_dbg
);

   // Result channel: a result transfers on any clock edge where res_valid and
   // res_ready are both high; while res_valid is high the result fields are frozen.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t                     state, state_nxt;
   logic [ADDR_W-1:0]          rp_nxt;
   logic [ADDR_W:0]            count, count_nxt;
   logic signed [2*DATA_W-1:0] result_nxt;
   logic [ADDR_W-1:0]          res_addr_nxt;
   logic                       res_err_nxt;
   logic                       res_valid_nxt;
   logic                       done_nxt;

   // Operands widened first so that MULT and MIN/-1 division cannot overflow.
   logic signed [2*DATA_W-1:0] a_ext, b_ext;
   logic signed [2*DATA_W-1:0] alu_res;
   logic                       alu_err;

   assign a_ext = {{DATA_W{rd_operand_a[DATA_W-1]}}, rd_operand_a};
   assign b_ext = {{DATA_W{rd_operand_b[DATA_W-1]}}, rd_operand_b};

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (rd_opcode)
         4'd0: alu_res = '0;
         4'd1: alu_res = a_ext;
         4'd2: alu_res = b_ext;
         4'd3: alu_res = a_ext + b_ext;
         4'd4: alu_res = a_ext - b_ext;
         4'd5: alu_res = a_ext * b_ext;
         4'd6: begin
            if (b_ext == '0) alu_err = 1'b1;
            else             alu_res = a_ext / b_ext;
         end
         4'd7: begin
            if (b_ext == '0) alu_err = 1'b1;
            else             alu_res = a_ext % b_ext;
         end
         default: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      rp_nxt        = read_pointer;
      count_nxt     = count;
      result_nxt    = result;
      res_addr_nxt  = res_addr;
      res_err_nxt   = res_err;
      res_valid_nxt = res_valid;
      done_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (num_instr != '0) begin
                  rp_nxt    = start_addr;
                  count_nxt = num_instr;
                  state_nxt = FETCH;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         FETCH: begin
            result_nxt    = alu_res;
            res_addr_nxt  = read_pointer;
            res_err_nxt   = alu_err;
            res_valid_nxt = 1'b1;
            state_nxt     = RESP;
         end
         RESP: begin
            if (res_valid && res_ready) begin
               res_valid_nxt = 1'b0;
               if (count == CNT_ONE) begin
                  count_nxt = '0;
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  count_nxt = count - CNT_ONE;
                  rp_nxt    = read_pointer + PTR_ONE;
                  state_nxt = FETCH;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         read_pointer <= '0;
         count        <= '0;
         result       <= '0;
         res_addr     <= '0;
         res_err      <= 1'b0;
         res_valid    <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         read_pointer <= rp_nxt;
         count        <= count_nxt;
         result       <= result_nxt;
         res_addr     <= res_addr_nxt;
         res_err      <= res_err_nxt;
         res_valid    <= res_valid_nxt;
         done         <= done_nxt;
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule
